// File: rtl/fpu_decode_pkg.sv
// Shared definitions for the FP decode stage.
// Holds the opcode and funct5 encodings, the type tags, the dynamic rounding
// mode code, the 16-bit control bundle and the buffered entry layout.
// Also provides two small helpers that map format codes to type tags.
package fpu_decode_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  // OP-FP funct5 (inst[31:27])
  localparam logic [4:0] F5_FADD    = 5'b00000;
  localparam logic [4:0] F5_FSUB    = 5'b00001;
  localparam logic [4:0] F5_FMUL    = 5'b00010;
  localparam logic [4:0] F5_FDIV    = 5'b00011;
  localparam logic [4:0] F5_FSGNJ   = 5'b00100;
  localparam logic [4:0] F5_FMINMAX = 5'b00101;
  localparam logic [4:0] F5_FCVT_FF = 5'b01000;
  localparam logic [4:0] F5_FSQRT   = 5'b01011;
  localparam logic [4:0] F5_FCMP    = 5'b10100;
  localparam logic [4:0] F5_FCVT_IF = 5'b11000;  // fcvt.{w,wu,l,lu}.fmt
  localparam logic [4:0] F5_FCVT_FI = 5'b11010;  // fcvt.fmt.{w,wu,l,lu}
  localparam logic [4:0] F5_FMV_XF  = 5'b11100;  // fmv.x.fmt / fclass
  localparam logic [4:0] F5_FMV_FX  = 5'b11110;  // fmv.fmt.x

  // Instruction format field encodings (inst[26:25], also rs2 of fcvt.fmt.fmt)
  localparam logic [1:0] FMT_S = 2'd0;
  localparam logic [1:0] FMT_D = 2'd1;
  localparam logic [1:0] FMT_H = 2'd2;
  localparam logic [1:0] FMT_Q = 2'd3;

  // Type tags seen by the FPU
  localparam logic [1:0] T_H = 2'd0;
  localparam logic [1:0] T_S = 2'd1;
  localparam logic [1:0] T_D = 2'd2;

  localparam logic [2:0] RM_DYN = 3'd7;

  typedef struct packed {
    logic       wen;
    logic       ren1;
    logic       ren2;
    logic       ren3;
    logic       swap12;
    logic       swap23;
    logic       fromint;
    logic       toint;
    logic       fastpipe;
    logic       fma;
    logic       div;
    logic       sqrt;
    logic       wflags;
    logic       illegal;
    logic [1:0] type_in;
  } fpu_ctrl_t;

  typedef struct packed {
    fpu_ctrl_t   sigs;
    logic [1:0]  type_out;
    logic [2:0]  rm;
    logic [31:0] inst;
  } dec_entry_t;

  function automatic logic [1:0] fmt_to_tag(input logic [1:0] fmt);
    case (fmt)
      FMT_S:   return T_S;
      FMT_D:   return T_D;
      default: return T_H;
    endcase
  endfunction

  // Loads/stores carry their precision in the width field (inst[14:12]);
  // inst[26:25] is immediate there. Unsupported widths map to Q (illegal).
  function automatic logic [1:0] width_to_fmt(input logic [2:0] width);
    case (width)
      3'b001:  return FMT_H;
      3'b010:  return FMT_S;
      3'b011:  return FMT_D;
      default: return FMT_Q;
    endcase
  endfunction

endpackage

// File: rtl/fpu_decode_stage_table.sv
// Combinational FP instruction decoder.
// Ports:
//   inst     in  32  instruction word
//   frm      in  3   fcsr.frm, used when the instruction selects dynamic rm
//   ctrl     out 16  control bundle (all zero except illegal when illegal)
//   type_out out 2   destination type tag (0 when illegal)
//   rm       out 3   resolved rm for rm-using ops, raw inst[14:12] otherwise
module fpu_decode_table
  import fpu_decode_pkg::*;
#(
  parameter int FLEN     = 64,
  parameter bit HAS_HALF = 1'b0
) (
  input  logic [31:0] inst,
  input  logic [2:0]  frm,
  output fpu_ctrl_t   ctrl,
  output logic [1:0]  type_out,
  output logic [2:0]  rm
);

  logic [6:0] opcode;
  logic [4:0] funct5;
  logic [1:0] fmt;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic       unused_inst_bits;

  assign opcode = inst[6:0];
  assign funct5 = inst[31:27];
  assign fmt    = inst[26:25];
  assign rs2    = inst[24:20];
  assign funct3 = inst[14:12];
  // Register specifiers are irrelevant to control decode.
  assign unused_inst_bits = ^{inst[19:15], inst[11:7]};

  function automatic logic fmt_ok(input logic [1:0] f);
    case (f)
      FMT_S:   return 1'b1;
      FMT_D:   return (FLEN == 64);
      FMT_H:   return HAS_HALF;
      default: return 1'b0;
    endcase
  endfunction

  logic       bad;
  logic       uses_rm;
  logic [1:0] src_fmt;
  logic [1:0] dst_fmt;
  logic [2:0] rm_res;

  always_comb begin
    ctrl     = '0;
    bad      = 1'b0;
    uses_rm  = 1'b0;
    src_fmt  = fmt;
    dst_fmt  = fmt;
    rm_res   = (funct3 == RM_DYN) ? frm : funct3;
    rm       = funct3;
    type_out = T_H;

    case (opcode)
      OPC_LOAD_FP: begin
        ctrl.wen = 1'b1;
        src_fmt  = width_to_fmt(funct3);
        dst_fmt  = src_fmt;
      end
      OPC_STORE_FP: begin
        ctrl.ren2 = 1'b1;
        src_fmt   = width_to_fmt(funct3);
        dst_fmt   = src_fmt;
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        {ctrl.wen, ctrl.ren1, ctrl.ren2, ctrl.ren3} = 4'b1111;
        {ctrl.fma, ctrl.wflags} = 2'b11;
        uses_rm = 1'b1;
      end
      OPC_OP_FP: begin
        case (funct5)
          F5_FADD, F5_FSUB, F5_FMUL: begin
            {ctrl.wen, ctrl.ren1, ctrl.ren2, ctrl.fma, ctrl.wflags} = 5'b11111;
            uses_rm = 1'b1;
          end
          F5_FDIV: begin
            {ctrl.wen, ctrl.ren1, ctrl.ren2, ctrl.div, ctrl.wflags} = 5'b11111;
            uses_rm = 1'b1;
          end
          F5_FSQRT: begin
            {ctrl.wen, ctrl.ren1, ctrl.sqrt, ctrl.wflags} = 4'b1111;
            uses_rm = 1'b1;
            bad     = (rs2 != 5'd0);
          end
          F5_FSGNJ: begin
            {ctrl.wen, ctrl.ren1, ctrl.ren2, ctrl.fastpipe} = 4'b1111;
            bad = (funct3 > 3'd2);
          end
          F5_FMINMAX: begin
            {ctrl.wen, ctrl.ren1, ctrl.ren2, ctrl.fastpipe, ctrl.wflags} = 5'b11111;
            bad = (funct3 > 3'd1);
          end
          F5_FCVT_FF: begin
            // Source precision lives in rs2; converting to itself is reserved.
            {ctrl.wen, ctrl.ren1, ctrl.fastpipe, ctrl.wflags} = 4'b1111;
            uses_rm = 1'b1;
            src_fmt = rs2[1:0];
            bad     = (rs2[4:2] != 3'd0) || (rs2[1:0] == fmt);
          end
          F5_FCMP: begin
            {ctrl.ren1, ctrl.ren2, ctrl.toint, ctrl.wflags} = 4'b1111;
            bad = (funct3 > 3'd2);
          end
          F5_FCVT_IF: begin
            {ctrl.ren1, ctrl.toint, ctrl.wflags} = 3'b111;
            uses_rm = 1'b1;
            bad     = (rs2[4:2] != 3'd0);
          end
          F5_FCVT_FI: begin
            {ctrl.wen, ctrl.fromint, ctrl.wflags} = 3'b111;
            uses_rm = 1'b1;
            bad     = (rs2[4:2] != 3'd0);
          end
          F5_FMV_XF: begin
            {ctrl.ren1, ctrl.toint} = 2'b11;
            bad = (rs2 != 5'd0) || (funct3 > 3'd1);
          end
          F5_FMV_FX: begin
            {ctrl.wen, ctrl.fromint} = 2'b11;
            bad = (rs2 != 5'd0) || (funct3 != 3'd0);
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    // Rounding mode only matters (and is only checked) for ops that round.
    if (uses_rm) begin
      rm = rm_res;
      if (rm_res == 3'd5 || rm_res == 3'd6) bad = 1'b1;
    end

    if (!fmt_ok(src_fmt) || !fmt_ok(dst_fmt)) bad = 1'b1;

    ctrl.type_in = fmt_to_tag(src_fmt);
    type_out     = fmt_to_tag(dst_fmt);

    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
      type_out     = T_H;
    end
  end

endmodule

// File: rtl/fpu_decode_stage.sv
// Registered, handshaked FP decode stage with a 2-entry skid buffer.
// Ports:
//   clock, reset                      clock, asynchronous active-high reset
//   io_in_valid/io_in_ready/io_in_inst  instruction input handshake
//   io_frm                             fcsr.frm, sampled on acceptance
//   io_flush                           drop everything buffered and offered
//   io_out_valid/io_out_ready          decoded bundle handshake
//   io_out_sigs, io_out_typeOut, io_out_rm, io_out_inst  decoded bundle
//   io_illegal_count                   saturating count of accepted illegals
module fpu_decode_stage
  import fpu_decode_pkg::*;
#(
  parameter int FLEN     = 64,
  parameter bit HAS_HALF = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [31:0]      io_in_inst,
  input  logic [2:0]       io_frm,
  input  logic             io_flush,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [15:0]      io_out_sigs,
  output logic [1:0]       io_out_typeOut,
  output logic [2:0]       io_out_rm,
  output logic [31:0]      io_out_inst,
  output logic [CNT_W-1:0] io_illegal_count
);

  fpu_ctrl_t  dec_ctrl;
  logic [1:0] dec_type;
  logic [2:0] dec_rm;
  dec_entry_t dec_entry;

  fpu_decode_table #(.FLEN(FLEN), .HAS_HALF(HAS_HALF)) u_table (
    .inst     (io_in_inst),
    .frm      (io_frm),
    .ctrl     (dec_ctrl),
    .type_out (dec_type),
    .rm       (dec_rm)
  );

  assign dec_entry = '{sigs: dec_ctrl, type_out: dec_type, rm: dec_rm, inst: io_in_inst};

  // Entry 0 is the head (drives the outputs), entry 1 is the skid slot.
  // Invariant: entry 1 valid implies entry 0 valid.
  dec_entry_t ent_reg  [2];
  dec_entry_t ent_next [2];
  logic       vld_reg  [2];
  logic       vld_next [2];
  logic       load_en  [2];
  logic       accept;
  logic       retire;

  assign accept = io_in_valid & ~vld_reg[1];
  assign retire = vld_reg[0] & io_out_ready;

  always_comb begin
    vld_next    = vld_reg;
    load_en[0]  = 1'b0;
    load_en[1]  = 1'b0;
    ent_next[0] = dec_entry;
    ent_next[1] = dec_entry;
    if (io_flush) begin
      vld_next[0] = 1'b0;
      vld_next[1] = 1'b0;
    end else if (retire) begin
      vld_next[1] = 1'b0;
      if (vld_reg[1]) begin
        // Full: promote the skid entry (no accept possible this cycle).
        load_en[0]  = 1'b1;
        ent_next[0] = ent_reg[1];
        vld_next[0] = 1'b1;
      end else begin
        load_en[0]  = accept;
        vld_next[0] = accept;
      end
    end else if (accept) begin
      if (vld_reg[0]) begin
        load_en[1]  = 1'b1;
        vld_next[1] = 1'b1;
      end else begin
        load_en[0]  = 1'b1;
        vld_next[0] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_reg[gi] <= 1'b0;
        ent_reg[gi] <= '0;
      end else begin
        vld_reg[gi] <= vld_next[gi];
        if (load_en[gi]) ent_reg[gi] <= ent_next[gi];
      end
    end
  end

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (accept && !io_flush && dec_ctrl.illegal && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign io_in_ready      = ~vld_reg[1];
  assign io_out_valid     = vld_reg[0];
  assign io_out_sigs      = ent_reg[0].sigs;
  assign io_out_typeOut   = ent_reg[0].type_out;
  assign io_out_rm        = ent_reg[0].rm;
  assign io_out_inst      = ent_reg[0].inst;
  assign io_illegal_count = cnt_reg;

endmodule

// File: tb/tb_fpu_decode_stage.sv
// Bench for fpu_decode_stage: two instances share stimulus, one F+D without
// half support and a 16-bit counter, one F-only with half support and a
// 2-bit counter. A queue-based model predicts each instance's outputs.
module tb_fpu_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [2:0]  frm;

  logic        in_ready_a, out_valid_a;
  logic [15:0] sigs_a;
  logic [1:0]  type_a;
  logic [2:0]  rm_a;
  logic [31:0] inst_a;
  logic [15:0] cnt_a;

  logic        in_ready_b, out_valid_b;
  logic [15:0] sigs_b;
  logic [1:0]  type_b;
  logic [2:0]  rm_b;
  logic [31:0] inst_b;
  logic [1:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [52:0] q_a[$];
  logic [52:0] q_b[$];
  int          cnt_model_a = 0;
  int          cnt_model_b = 0;
  bit          acc;

  always #5 clock = ~clock;

  fpu_decode_stage #(.FLEN(64), .HAS_HALF(1'b0), .CNT_W(16)) dut_a (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready_a), .io_in_inst(in_inst),
    .io_frm(frm), .io_flush(flush),
    .io_out_valid(out_valid_a), .io_out_ready(out_ready),
    .io_out_sigs(sigs_a), .io_out_typeOut(type_a), .io_out_rm(rm_a),
    .io_out_inst(inst_a), .io_illegal_count(cnt_a)
  );

  fpu_decode_stage #(.FLEN(32), .HAS_HALF(1'b1), .CNT_W(2)) dut_b (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(in_ready_b), .io_in_inst(in_inst),
    .io_frm(frm), .io_flush(flush),
    .io_out_valid(out_valid_b), .io_out_ready(out_ready),
    .io_out_sigs(sigs_b), .io_out_typeOut(type_b), .io_out_rm(rm_b),
    .io_out_inst(inst_b), .io_illegal_count(cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Control-bundle bit masks, MSB = wen ... bit2 = illegal, bits1:0 = typeIn
  localparam logic [15:0] M_WEN = 16'h8000, M_R1 = 16'h4000, M_R2 = 16'h2000;
  localparam logic [15:0] M_R3  = 16'h1000, M_FI = 16'h0200, M_TI = 16'h0100;
  localparam logic [15:0] M_FP  = 16'h0080, M_FMA = 16'h0040, M_DIV = 16'h0020;
  localparam logic [15:0] M_SQ  = 16'h0010, M_WF = 16'h0008, M_ILL = 16'h0004;

  // format code 0=S,1=D,2=H,3=Q  -> tag H=0,S=1,D=2
  function automatic int tag_of(input int f);
    return (f == 0) ? 1 : (f == 1) ? 2 : 0;
  endfunction

  function automatic bit fmt_legal(input int f, input int flen, input bit half);
    return (f == 0) || (f == 1 && flen == 64) || (f == 2 && half);
  endfunction

  // Returns {sigs[15:0], typeOut[1:0], rm[2:0]} for one instruction.
  function automatic logic [20:0] ref_decode(input logic [31:0] w, input logic [2:0] frm_v,
                                             input int flen, input bit half);
    int op, f5, fmt, rs2, f3, src, rmv;
    bit legal, rmop;
    logic [15:0] s;
    op = int'(w[6:0]); f5 = int'(w[31:27]); fmt = int'(w[26:25]);
    rs2 = int'(w[24:20]); f3 = int'(w[14:12]);
    legal = 1; rmop = 0; s = '0; src = fmt;
    if (op == 'h07 || op == 'h27) begin
      src = (f3 == 1) ? 2 : (f3 == 2) ? 0 : (f3 == 3) ? 1 : 3;
      fmt = src;
      s = (op == 'h07) ? M_WEN : M_R2;
    end else if (op == 'h43 || op == 'h47 || op == 'h4b || op == 'h4f) begin
      s = M_WEN | M_R1 | M_R2 | M_R3 | M_FMA | M_WF; rmop = 1;
    end else if (op == 'h53) begin
      case (f5)
        0, 1, 2: begin s = M_WEN | M_R1 | M_R2 | M_FMA | M_WF; rmop = 1; end
        3:  begin s = M_WEN | M_R1 | M_R2 | M_DIV | M_WF; rmop = 1; end
        11: begin s = M_WEN | M_R1 | M_SQ | M_WF; rmop = 1; legal = (rs2 == 0); end
        4:  begin s = M_WEN | M_R1 | M_R2 | M_FP; legal = (f3 <= 2); end
        5:  begin s = M_WEN | M_R1 | M_R2 | M_FP | M_WF; legal = (f3 <= 1); end
        8:  begin s = M_WEN | M_R1 | M_FP | M_WF; rmop = 1; src = rs2;
                  legal = (rs2 < 4) && (rs2 != fmt); end
        20: begin s = M_R1 | M_R2 | M_TI | M_WF; legal = (f3 <= 2); end
        24: begin s = M_R1 | M_TI | M_WF; rmop = 1; legal = (rs2 < 4); end
        26: begin s = M_WEN | M_FI | M_WF; rmop = 1; legal = (rs2 < 4); end
        28: begin s = M_R1 | M_TI; legal = (rs2 == 0) && (f3 <= 1); end
        30: begin s = M_WEN | M_FI; legal = (rs2 == 0) && (f3 == 0); end
        default: legal = 0;
      endcase
    end else begin
      legal = 0;
    end
    rmv = (f3 == 7) ? int'(frm_v) : f3;
    if (rmop && (rmv == 5 || rmv == 6)) legal = 0;
    if (!fmt_legal(src, flen, half) || !fmt_legal(fmt, flen, half)) legal = 0;
    if (!legal) return {M_ILL, 2'd0, 3'(rmop ? rmv : f3)};
    return {s | 16'(tag_of(src)), 2'(tag_of(fmt)), 3'(rmop ? rmv : f3)};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [4:0]  f5_list [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8,
                                  5'd11, 5'd20, 5'd24, 5'd26, 5'd28, 5'd30};
    int k, j;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[24:22] = 3'b000;
    if ($urandom_range(0, 2) == 0) w[21:20] = 2'b00;
    k = $urandom_range(0, 9);
    case (k)
      0: w[6:0] = 7'h07;
      1: w[6:0] = 7'h27;
      2: w[6:0] = {3'b100, w[3:2], 2'b11};
      9: ;
      default: begin
        w[6:0] = 7'h53;
        j = $urandom_range(0, 13);
        if (j < 13) w[31:27] = f5_list[j];
      end
    endcase
    return w;
  endfunction

  // Compare both DUTs with the model, advance the model over this cycle's
  // inputs, then move to 1 time unit after the next rising edge.
  task automatic step(output bit accepted);
    logic [20:0] da, db;
    bit ra, rb;
    check("a_in_ready", in_ready_a, q_a.size() < 2);
    check("a_out_valid", out_valid_a, q_a.size() > 0);
    if (q_a.size() > 0) check("a_bundle", {sigs_a, type_a, rm_a, inst_a}, q_a[0]);
    check("a_count", cnt_a, cnt_model_a);
    check("b_in_ready", in_ready_b, q_b.size() < 2);
    check("b_out_valid", out_valid_b, q_b.size() > 0);
    if (q_b.size() > 0) check("b_bundle", {sigs_b, type_b, rm_b, inst_b}, q_b[0]);
    check("b_count", cnt_b, cnt_model_b);
    accepted = in_valid && (q_a.size() < 2);
    da = ref_decode(in_inst, frm, 64, 1'b0);
    db = ref_decode(in_inst, frm, 32, 1'b1);
    ra = (q_a.size() > 0) && out_ready;
    rb = (q_b.size() > 0) && out_ready;
    if (flush) begin
      q_a.delete();
      q_b.delete();
      accepted = 0;
    end else begin
      if (ra) void'(q_a.pop_front());
      if (rb) void'(q_b.pop_front());
      if (accepted) begin
        q_a.push_back({da, in_inst});
        q_b.push_back({db, in_inst});
        if (da[7] && cnt_model_a < 65535) cnt_model_a++;
        if (db[7] && cnt_model_b < 3) cnt_model_b++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_list [4];
    int idx, ndeliv;

    reset = 1'b1; in_valid = 0; flush = 0; out_ready = 0; in_inst = '0; frm = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_out_valid", out_valid_a, 0);
    check("rst_in_ready", in_ready_a, 1);
    check("rst_sigs", sigs_a, 0);
    check("rst_inst", inst_a, 0);
    check("rst_count_a", cnt_a, 0);
    check("rst_count_b", cnt_b, 0);
    step(acc);

    // fadd.s, dynamic rm with frm=3
    in_valid = 1; in_inst = 32'h00B57553; frm = 3'd3; out_ready = 1;
    step(acc);
    in_valid = 0;
    check("t1_valid", out_valid_a, 1);
    check("t1_sigs", sigs_a, 16'hE049);
    check("t1_type", type_a, 1);
    check("t1_rm", rm_a, 3);
    step(acc);

    // fdiv.d: legal with FLEN=64, illegal with FLEN=32
    in_valid = 1; in_inst = 32'h1AB57553; frm = 3'd0;
    step(acc);
    in_valid = 0;
    check("t2_div_d", sigs_a, 16'hE02A);
    check("t2_type_d", type_a, 2);
    check("t2_illegal_flen32", sigs_b, 16'h0004);
    step(acc);
    check("t2_count_flen32", cnt_b, 1);

    // fsqrt.s with reserved frm, then with frm=0
    in_valid = 1; in_inst = 32'h58057553; frm = 3'd5;
    step(acc);
    check("t3_rm_reserved", sigs_a, 16'h0004);
    frm = 3'd0;
    step(acc);
    in_valid = 0;
    check("t3_sqrt", sigs_a, 16'hC019);
    check("t3_rm", rm_a, 0);
    step(acc);

    // Back-pressure: 4 instructions, out_ready low for 3 cycles
    bp_list[0] = 32'h00B57553; bp_list[1] = 32'h58057553;
    bp_list[2] = 32'h10B57553; bp_list[3] = 32'h20B50553;
    frm = 3'd3; idx = 0; ndeliv = 0;
    for (int cyc = 0; cyc < 20 && (idx < 4 || q_a.size() > 0); cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (idx < 4);
      in_inst   = bp_list[idx % 4];
      if (out_valid_a && out_ready) begin
        check("t4_order", inst_a, bp_list[ndeliv % 4]);
        ndeliv++;
      end
      step(acc);
      if (acc) idx++;
      if (cyc == 1) check("t4_in_ready_low", in_ready_a, 0);
    end
    in_valid = 0;
    check("t4_delivered", ndeliv, 4);

    // Flush at occupancy 2 while an illegal instruction is offered
    out_ready = 0; in_valid = 1; in_inst = 32'h00B57553;
    step(acc);
    step(acc);
    flush = 1; in_inst = 32'h00000000;
    step(acc);
    flush = 0; in_valid = 0;
    check("t5_out_valid", out_valid_a, 0);
    check("t5_in_ready", in_ready_a, 1);
    check("t5_count", cnt_a, cnt_model_a);
    step(acc);

    // Asynchronous reset mid-stream
    in_valid = 1; in_inst = 32'h00000000;
    step(acc);
    step(acc);
    reset = 1'b1;
    #2;
    check("t6_rst_out_valid", out_valid_a, 0);
    check("t6_rst_in_ready", in_ready_a, 1);
    check("t6_rst_sigs", sigs_a, 0);
    check("t6_rst_count_a", cnt_a, 0);
    check("t6_rst_count_b", cnt_b, 0);
    q_a.delete(); q_b.delete(); cnt_model_a = 0; cnt_model_b = 0;
    in_valid = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(acc);

    // Saturation of the 2-bit counter with 5 illegal instructions
    out_ready = 1; in_valid = 1; in_inst = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) step(acc);
    in_valid = 0;
    step(acc);
    check("t6_sat_b", cnt_b, 3);
    check("t6_count_a", cnt_a, 5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 29) == 0);
      in_inst   = rand_inst();
      frm       = 3'($urandom_range(0, 7));
      step(acc);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (3) step(acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
